// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Bundles the producer handshake and the fifo write-side signals seen by
// fifo_wr_arbiter. The arbiter connects through the "master" modport. The
// environment (producers, fifo, testbench) connects through the "slave"
// modport.
//
// Signals
//   req_valid     [N_REQ]         producer -> arbiter, word valid
//   req_data      [N_REQ*DATA_W]  producer -> arbiter, word i at [i*DATA_W +: DATA_W]
//   req_ready     [N_REQ]         arbiter -> producer, word accepted this cycle
//   fifo_data_in  [DATA_W]        arbiter -> fifo data_in
//   fifo_write_en                 arbiter -> fifo write_en
//   fifo_full                     fifo -> arbiter, full flag
//   owner         [OWNER_W]       index of the current or last granted producer
//   busy                          high while a grant is active
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);
   localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]       fifo_data_in;
   logic                    fifo_write_en;
   logic                    fifo_full;
   logic [OWNER_W-1:0]      owner;
   logic                    busy;

   modport master (
      input  req_valid,
      input  req_data,
      input  fifo_full,
      output req_ready,
      output fifo_data_in,
      output fifo_write_en,
      output owner,
      output busy
   );

   modport slave (
      output req_valid,
      output req_data,
      output fifo_full,
      input  req_ready,
      input  fifo_data_in,
      input  fifo_write_en,
      input  owner,
      input  busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one fifo write port between N_REQ
// valid/ready producers. A producer is granted for a burst of up to
// MAX_BURST words. After the burst, the grant returns to IDLE for a single
// arbitration cycle. The granted word is presented to the fifo in the same
// cycle as its handshake. A full fifo stalls the owner and does not drop
// the owner's grant.
//
// Ports
//   clk     clock; all state updates on the rising edge
//   rst_n   asynchronous active-low reset
//   bus     fifo_wr_arbiter_if.master; carries the producer handshake, the
//           fifo write side, and the owner/busy status outputs
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   fifo_wr_arbiter_if.master   bus
);

   localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [OWNER_W-1:0] OWNER_LAST = OWNER_W'(N_REQ - 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
   localparam logic [OWNER_W:0]   N_REQ_EXT  = (OWNER_W+1)'(N_REQ);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t              state_reg,      state_next;
   logic [OWNER_W-1:0]  owner_reg,      owner_next;
   logic [OWNER_W-1:0]  last_owner_reg, last_owner_next;
   logic [BURST_W-1:0]  burst_cnt_reg,  burst_cnt_next;

   // ------------------------------------------------------------------------
   // Round-robin candidate search.
   // cand_idx[k] is the producer at distance k+1 from last_owner, wrapped
   // modulo N_REQ. The lowest k whose producer is valid wins, so the search
   // starts at last_owner+1 and visits last_owner itself only at the end.
   // ------------------------------------------------------------------------
   logic [OWNER_W-1:0] cand_idx [N_REQ];
   logic [N_REQ-1:0]   cand_hit;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
         logic [OWNER_W:0] sum;
         // The sum is at most 2*N_REQ-1, so one conditional subtract wraps it.
         assign sum = {1'b0, last_owner_reg} + (OWNER_W+1)'(gi + 1);
         assign cand_idx[gi] = (sum >= N_REQ_EXT) ? OWNER_W'(sum - N_REQ_EXT)
                                                  : sum[OWNER_W-1:0];
         assign cand_hit[gi] = bus.req_valid[cand_idx[gi]];
      end
   endgenerate

   logic [OWNER_W-1:0] pick_idx;
   logic               pick_any;

   always_comb begin
      pick_idx = cand_idx[0];
      // Walk downward so that the nearest hit is the last one written.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            pick_idx = cand_idx[k];
         end
      end
   end

   assign pick_any = |bus.req_valid;

   // ------------------------------------------------------------------------
   // Owner-side handshake qualifiers
   // ------------------------------------------------------------------------
   logic granted;
   logic owner_valid;
   logic xfer;

   assign granted     = (state_reg == ST_GRANT);
   assign owner_valid = bus.req_valid[owner_reg];
   assign xfer        = granted && owner_valid && !bus.fifo_full;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= '0;
         // Makes producer 0 the first in line after reset.
         last_owner_reg <= OWNER_LAST;
         burst_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         burst_cnt_reg  <= burst_cnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      burst_cnt_next  = burst_cnt_reg;

      unique case (state_reg)
         ST_IDLE: begin
            // Arbitration bubble: select a new owner here, transfer nothing.
            if (pick_any) begin
               owner_next     = pick_idx;
               burst_cnt_next = '0;
               state_next     = ST_GRANT;
            end
         end

         ST_GRANT: begin
            if (xfer) begin
               if (burst_cnt_reg == BURST_LAST) begin
                  state_next      = ST_IDLE;
                  last_owner_next = owner_reg;
               end else begin
                  burst_cnt_next = burst_cnt_reg + 1'b1;
               end
            end else if (!owner_valid) begin
               // The owner has nothing more to send, so hand the port back early.
               state_next      = ST_IDLE;
               last_owner_next = owner_reg;
            end
            // Otherwise the owner is valid and the fifo is full. The owner
            // waits with the grant held and the count frozen.
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode. All outputs are combinational from the state, so the
   // asynchronous reset forces them to idle values at once.
   // ------------------------------------------------------------------------
   logic [N_REQ-1:0]  ready_vec;
   logic [DATA_W-1:0] data_mux;

   always_comb begin
      ready_vec = '0;
      data_mux  = '0;
      if (granted) begin
         ready_vec[owner_reg] = !bus.fifo_full;
         data_mux             = bus.req_data[owner_reg*DATA_W +: DATA_W];
      end
   end

   assign bus.req_ready     = ready_vec;
   assign bus.fifo_data_in  = data_mux;
   assign bus.fifo_write_en = xfer;
   assign bus.owner         = owner_reg;
   assign bus.busy          = granted;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed testbench for fifo_wr_arbiter with N_REQ=4, DATA_W=8 and
// MAX_BURST=4. Producer i presents base[i] + cnt[i]. cnt[i] advances after
// each accepted word, so the expected fifo data is known ahead of time.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   fifo_wr_arbiter #(
      .N_REQ    (N_REQ),
      .DATA_W   (DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cnt  [N_REQ];
   int base [N_REQ];
   int own_seq [5];

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one clock. Sampling happens 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_data();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_data[i*DATA_W +: DATA_W] = DATA_W'(base[i] + cnt[i]);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         cnt[i]  = 0;
         base[i] = i * 16;
      end
      drive_data();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   // The arbiter is expected to be in IDLE. Check this, then step one cycle.
   task automatic expect_idle(input string tag);
      check_val({tag, " busy"},  32'(bus.busy), 32'd0);
      check_val({tag, " wr_en"}, 32'(bus.fifo_write_en), 32'd0);
      check_val({tag, " ready"}, 32'(bus.req_ready), 32'd0);
      tick();
   endtask

   // A word from producer own is expected this cycle. Check it, step, then
   // advance that producer's data.
   task automatic expect_word(input string tag, input int own);
      check_val({tag, " busy"},  32'(bus.busy), 32'd1);
      check_val({tag, " owner"}, 32'(bus.owner), 32'(own));
      check_val({tag, " wr_en"}, 32'(bus.fifo_write_en), 32'd1);
      check_val({tag, " ready"}, 32'(bus.req_ready), 32'(1 << own));
      check_val({tag, " data"},  32'(bus.fifo_data_in), 32'((base[own] + cnt[own]) & 8'hff));
      tick();
      cnt[own]++;
      drive_data();
      #1;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      own_seq[0] = 0; own_seq[1] = 1; own_seq[2] = 2; own_seq[3] = 3; own_seq[4] = 0;

      // ---------------- reset values while rst_n is low ----------------
      bus.req_valid = 4'b1111;
      #3;
      check_val("rst ready", 32'(bus.req_ready), 32'd0);
      check_val("rst wr_en", 32'(bus.fifo_write_en), 32'd0);
      check_val("rst data",  32'(bus.fifo_data_in), 32'd0);
      check_val("rst busy",  32'(bus.busy), 32'd0);
      check_val("rst owner", 32'(bus.owner), 32'd0);

      // ---------------- single producer ----------------
      do_reset();
      base[2] = 8'h10;
      drive_data();
      bus.req_valid = 4'b0100;
      #1;
      expect_idle("t1 idle");
      for (int w = 0; w < 4; w++) expect_word("t1 word", 2);
      bus.req_valid = 4'b0000;
      #1;
      check_val("t1 owner held", 32'(bus.owner), 32'd2);
      expect_idle("t1 end");

      // ---------------- round-robin fairness ----------------
      do_reset();
      bus.req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 5; g++) begin
         expect_idle("t2 bubble");
         for (int w = 0; w < 4; w++) expect_word("t2 word", own_seq[g]);
      end

      // ---------------- full back-pressure ----------------
      do_reset();
      bus.req_valid = 4'b0010;
      #1;
      expect_idle("t3 idle");
      expect_word("t3 word", 1);
      expect_word("t3 word", 1);
      bus.fifo_full = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         check_val("t3 stall ready", 32'(bus.req_ready), 32'd0);
         check_val("t3 stall wr_en", 32'(bus.fifo_write_en), 32'd0);
         check_val("t3 stall busy",  32'(bus.busy), 32'd1);
         check_val("t3 stall owner", 32'(bus.owner), 32'd1);
         tick();
      end
      bus.fifo_full = 1'b0;
      #1;
      expect_word("t3 resume", 1);
      expect_word("t3 resume", 1);
      expect_idle("t3 release");

      // ---------------- early release ----------------
      do_reset();
      bus.req_valid = 4'b1001;
      #1;
      expect_idle("t4 idle");
      expect_word("t4 word", 0);
      bus.req_valid = 4'b1000;
      #1;
      check_val("t4 drop wr_en", 32'(bus.fifo_write_en), 32'd0);
      check_val("t4 drop busy",  32'(bus.busy), 32'd1);
      tick();
      expect_idle("t4 rearb");
      expect_word("t4 next", 3);

      // ---------------- wrap-around (last_owner = 3) ----------------
      bus.req_valid = 4'b0000;
      #1;
      check_val("t5 drop wr_en", 32'(bus.fifo_write_en), 32'd0);
      tick();
      bus.req_valid = 4'b0011;
      #1;
      expect_idle("t5 idle");
      expect_word("t5 wrap", 0);

      // ---------------- reset mid-burst ----------------
      do_reset();
      bus.req_valid = 4'b0001;
      #1;
      expect_idle("t6 idle");
      expect_word("t6 word", 0);
      expect_word("t6 word", 0);
      check_val("t6 pre busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("t6 async wr_en", 32'(bus.fifo_write_en), 32'd0);
      check_val("t6 async ready", 32'(bus.req_ready), 32'd0);
      check_val("t6 async busy",  32'(bus.busy), 32'd0);
      check_val("t6 async owner", 32'(bus.owner), 32'd0);
      check_val("t6 async data",  32'(bus.fifo_data_in), 32'd0);
      bus.req_valid = 4'b0011;
      tick();
      rst_n = 1'b1;
      #1;
      expect_idle("t6 post idle");
      expect_word("t6 post grant", 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the 8-bit fifo between N_REQ producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words. It drives fifo data_in/write_en directly and back-pressures all producers from the fifo full flag. It sits between the producer blocks and the fifo write side; the fifo read side is unaffected.

Parameters:
N_REQ, 4, number of requesting producers (2..16)
DATA_W, 8, word width; matches fifo data_in
MAX_BURST, 4, maximum words accepted per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-producer word-valid
req_data  input  N_REQ*DATA_W  producer i word at bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  per-producer accept; a transfer occurs when req_valid[i] & req_ready[i]
fifo_data_in  output  DATA_W  to fifo data_in
fifo_write_en  output  1  to fifo write_en
fifo_full  input  1  from fifo full
owner  output  $clog2(N_REQ)  index of current/last granted producer
busy  output  1  high while in GRANT state

Behaviour:
- Reset (async assert, sync release): state=IDLE, owner=0, last_owner=N_REQ-1 (so producer 0 wins the first arbitration), burst_cnt=0. Outputs during reset: req_ready=0, fifo_write_en=0, fifo_data_in=0, busy=0, owner=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from last_owner+1 with modulo-N_REQ wrap. Register it into owner, clear burst_cnt, go to GRANT next cycle.
  - If no req_valid bit is set, stay in IDLE.
  - No transfers occur in IDLE, giving 1 arbitration bubble per grant.
- GRANT, combinational outputs:
  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
  - fifo_write_en = req_valid[owner] & !fifo_full.
  - fifo_data_in = req_data slice of owner while in GRANT, else 0.
  - The word reaches the fifo in the same cycle as the handshake (zero latency).
- GRANT, transitions (evaluated at each clock edge):
  - Transfer with burst_cnt==MAX_BURST-1: go to IDLE, last_owner=owner.
  - Transfer otherwise: burst_cnt+1, stay in GRANT.
  - req_valid[owner]==0: release the grant, go to IDLE, last_owner=owner. No transfer this cycle.
  - req_valid[owner]==1 & fifo_full: stall. Stay in GRANT, burst_cnt held, no timeout.
- fifo_write_en is never high while fifo_full is high. No word is dropped or duplicated.
- Producer rule: once req_valid is high, req_data must be held stable until the transfer. The arbiter does not check this.
- Requests from non-owners are ignored until the next IDLE arbitration.
- owner holds its value in IDLE; busy = (state==GRANT).
- Reset mid-burst: state returns to IDLE immediately and asynchronously, and outputs go to their reset values. Words already written stay in the fifo; the current word is not written.
- MAX_BURST=1: every transfer returns to IDLE, giving strict word-level round robin.

Test Plan:
- Single producer: after reset, req_valid=4'b0100 with data 0x10..0x13 held per handshake, fifo empty. Required: 1 IDLE cycle, owner=2, then 4 consecutive fifo_write_en pulses carrying 0x10,0x11,0x12,0x13, then IDLE.
- Round-robin fairness: all 4 producers continuously valid, MAX_BURST=4. Required: grants in order 0,1,2,3,0. Each grant is 4 consecutive writes followed by a 1-cycle bubble. Producer i data is seen at the fifo in burst order.
- Full back-pressure: owner=1 mid-burst after 2 words, force fifo_full=1 for 5 cycles. Required: req_ready=0 and fifo_write_en=0 for those 5 cycles, busy=1, owner=1. After full clears, the remaining 2 words are written and then the grant releases.
- Early release: owner=0 drops req_valid after 1 word, while producer 3 is valid. Required: the next cycle is IDLE, and the following grant goes to owner=3 (search 1,2,3; 1 and 2 idle).
- Wrap-around: last_owner=3, req_valid=4'b0011. Required: owner=0 is granted next, not 1.
- Reset mid-burst: assert rst_n=0 after the 2nd word of a burst. Required: fifo_write_en, req_ready and busy drop to 0 without waiting for clk. After release, the first grant goes to producer 0.
